// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between pipeline writeback (port 0)
// and the multi-cycle unit (port 1). It also tracks registers still owed a port-1 result.
package regfile_wb_arbiter_pkg;
  typedef logic [31:0] data_t;
endpackage

module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic [4:0]  p0_rd,
  input  data_t       p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_rd,
  input  data_t       p1_data,
  output logic        p1_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_rd,
  output logic [31:0] pending,
  output logic        rf_we,
  output logic [4:0]  rf_rd_addr,
  output data_t       rf_rd_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a port transfers on a cycle where valid && ready are both high.
  // The requester holds valid/rd/data stable until that cycle. Ready depends
  // only on the valids and the starvation count, never on rd or data.
  logic        force1;
  logic        p0_acc;
  logic        p1_acc;
  logic        wr_en;
  logic [4:0]  wr_rd;
  data_t       wr_data;
  logic [3:0]  starve;
  logic [3:0]  starve_next;
  logic [31:0] pending_next;

  always_comb begin
    force1   = p1_valid && (starve == LIMIT);
    p0_ready = !force1;
    p1_ready = force1 || !p0_valid;
    p0_acc   = p0_valid && p0_ready;
    p1_acc   = p1_valid && p1_ready;

    wr_rd   = p0_acc ? p0_rd : p1_rd;
    wr_data = p0_acc ? p0_data : p1_data;
    // x0 writes complete the handshake but never reach the regfile.
    wr_en   = (p0_acc || p1_acc) && (wr_rd != 5'd0);

    starve_next = starve;
    if (!p1_valid || p1_acc) starve_next = 4'd0;
    else if (starve != LIMIT) starve_next = starve + 4'd1;

    // The set is applied after the clear, so a same-cycle reservation wins.
    pending_next = pending;
    if (p1_acc) pending_next[p1_rd] = 1'b0;
    if (rsv_valid && (rsv_rd != 5'd0)) pending_next[rsv_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve     <= 4'd0;
      pending    <= 32'd0;
      rf_we      <= 1'b0;
      rf_rd_addr <= 5'd0;
      rf_rd_data <= '0;
    end else begin
      starve     <= starve_next;
      pending    <= pending_next;
      rf_we      <= wr_en;
      rf_rd_addr <= wr_en ? wr_rd : 5'd0;
      rf_rd_data <= wr_en ? wr_data : '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a reference model pushes the expected regfile
// write for every cycle into exp_q, and each scenario pops and compares it.
module tb_regfile_wb_arbiter;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_valid = 1'b0;
  logic [4:0]  p0_rd = '0;
  logic [31:0] p0_data = '0;
  logic        p0_ready;
  logic        p1_valid = 1'b0;
  logic [4:0]  p1_rd = '0;
  logic [31:0] p1_data = '0;
  logic        p1_ready;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_rd = '0;
  logic [31:0] pending;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_rd(p0_rd), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data), .p1_ready(p1_ready),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .pending(pending),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [37:0] exp_q[$];
  logic [37:0] e;
  logic [3:0]  m_starve = '0;
  logic [31:0] m_pend = '0;
  logic        act_p0r, act_p1r, acc0, acc1;
  int          n_total = 0;
  int          n_pass = 0;

  // Driver: inputs are already set; sample ready mid-cycle, advance the model,
  // push the expected regfile write and step through one rising edge.
  task automatic tick();
    logic f1, e0r, e1r, a0, a1;
    #1;
    act_p0r = p0_ready;
    act_p1r = p1_ready;
    f1  = p1_valid && (m_starve == 4'(STARVE_LIMIT));
    e0r = !f1;
    e1r = f1 || !p0_valid;
    a0  = p0_valid && e0r;
    a1  = p1_valid && e1r;
    acc0 = a0 && !rst;
    acc1 = a1 && !rst;
    if (rst) begin
      exp_q.push_back(38'd0);
      m_starve = '0;
      m_pend   = '0;
    end else begin
      if (a0)      exp_q.push_back(p0_rd != 0 ? {1'b1, p0_rd, p0_data} : 38'd0);
      else if (a1) exp_q.push_back(p1_rd != 0 ? {1'b1, p1_rd, p1_data} : 38'd0);
      else         exp_q.push_back(38'd0);
      if (!p1_valid || a1) m_starve = '0;
      else if (m_starve < 4'(STARVE_LIMIT)) m_starve = m_starve + 4'd1;
      if (a1) m_pend[p1_rd] = 1'b0;
      if (rsv_valid && rsv_rd != 0) m_pend[rsv_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p0_valid = 1'b1; p0_rd = 5'd1; p0_data = 32'h11;
    p1_valid = 1'b1; p1_rd = 5'd2; p1_data = 32'h22;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_total++;
      if ({rf_we, rf_rd_addr, rf_rd_data, pending} !== 70'd0)
        $display("FAIL reset_outputs[%0d]: got we=%b addr=%0d data=%h pend=%h, want all 0",
                 i, rf_we, rf_rd_addr, rf_rd_data, pending);
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if ({act_p0r, act_p1r} !== 2'b10)
          $display("FAIL reset_ready: got %b%b, want 10", act_p0r, act_p1r);
        else n_pass++;
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (acc0) p0_valid = 1'b0;
      if (acc1) p1_valid = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({rf_we, rf_rd_addr, rf_rd_data} !== e)
        $display("FAIL post_reset_write[%0d]: got %h, want %h", i, {rf_we, rf_rd_addr, rf_rd_data}, e);
      else n_pass++;
    end
  endtask

  task automatic test_p0_alone();
    p0_valid = 1'b1; p0_rd = 5'd5; p0_data = 32'hDEADBEEF;
    tick();
    p0_valid = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if ({rf_we, rf_rd_addr, rf_rd_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL p0_alone: got we=%b addr=%0d data=%h, want 1 5 deadbeef", rf_we, rf_rd_addr, rf_rd_data);
    else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if ({rf_we, rf_rd_addr, rf_rd_data} !== e)
      $display("FAIL p0_idle: got %h, want %h", {rf_we, rf_rd_addr, rf_rd_data}, e);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic want_p1;
    p0_valid = 1'b1; p0_rd = 5'd3; p0_data = $urandom;
    p1_valid = 1'b1; p1_rd = 5'd9; p1_data = $urandom;
    for (int i = 0; i < 10; i++) begin
      tick();
      want_p1 = ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
      n_total++;
      if ({act_p0r, act_p1r} !== {!want_p1, want_p1})
        $display("FAIL contention_ready[%0d]: got p0r=%b p1r=%b, want p0r=%b p1r=%b",
                 i, act_p0r, act_p1r, !want_p1, want_p1);
      else n_pass++;
      n_total++;
      if (act_p0r && act_p1r)
        $display("FAIL contention_double_accept[%0d]: got both ready, want one", i);
      else n_pass++;
      e = exp_q.pop_front();
      n_total++;
      if ({rf_we, rf_rd_addr, rf_rd_data} !== e || rf_we !== 1'b1)
        $display("FAIL contention_write[%0d]: got %h, want %h", i, {rf_we, rf_rd_addr, rf_rd_data}, e);
      else n_pass++;
      if (acc0) p0_data = $urandom;
      if (acc1) p1_data = $urandom;
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if ({rf_we, rf_rd_addr, rf_rd_data} !== e)
      $display("FAIL contention_drain: got %h, want %h", {rf_we, rf_rd_addr, rf_rd_data}, e);
    else n_pass++;
  endtask

  task automatic test_pending();
    bit          sv[6] = '{1, 0, 1, 1, 1, 0};
    logic [4:0]  sr[6] = '{5'd7, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0};
    bit          pv[6] = '{0, 1, 0, 1, 0, 1};
    logic [31:0] ep[6] = '{32'h80, 32'h0, 32'h80, 32'h80, 32'h80, 32'h0};
    p1_rd = 5'd7;
    for (int i = 0; i < 6; i++) begin
      rsv_valid = sv[i]; rsv_rd = sr[i];
      p1_valid = pv[i]; p1_data = $urandom;
      tick();
      e = exp_q.pop_front();
      n_total++;
      if (pending !== ep[i])
        $display("FAIL pending_step[%0d]: got %h, want %h", i, pending, ep[i]);
      else n_pass++;
      n_total++;
      if ({rf_we, rf_rd_addr, rf_rd_data} !== e)
        $display("FAIL pending_write[%0d]: got %h, want %h", i, {rf_we, rf_rd_addr, rf_rd_data}, e);
      else n_pass++;
    end
    rsv_valid = 1'b0; p1_valid = 1'b0;
  endtask

  task automatic test_x0();
    p1_valid = 1'b1; p1_rd = 5'd0; p1_data = 32'h1234;
    tick();
    p1_valid = 1'b0;
    n_total++;
    if (act_p1r !== 1'b1) $display("FAIL x0_ready: got %b, want 1", act_p1r);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if ({rf_we, rf_rd_addr, rf_rd_data} !== 38'd0)
      $display("FAIL x0_write: got we=%b addr=%0d data=%h, want 0 0 0", rf_we, rf_rd_addr, rf_rd_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int r = 1; r < 16; r++) begin
      rsv_valid = 1'b1; rsv_rd = 5'(r);
      tick();
      e = exp_q.pop_front();
    end
    rsv_valid = 1'b0;
    n_total++;
    if (pending !== 32'hFFFE || pending !== m_pend)
      $display("FAIL mid_pending_fill: got %h, want %h", pending, 32'hFFFE);
    else n_pass++;
    p1_valid = 1'b1; p1_rd = 5'd20; p1_data = $urandom;
    tick();
    p1_valid = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if ({rf_we, rf_rd_addr, rf_rd_data} !== e)
      $display("FAIL mid_p1_write: got %h, want %h", {rf_we, rf_rd_addr, rf_rd_data}, e);
    else n_pass++;
    rst = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if ({rf_we, pending} !== 33'd0)
      $display("FAIL mid_reset: got we=%b pend=%h, want 0 0", rf_we, pending);
    else n_pass++;
    // Build up starvation, then reset while it would otherwise reach the limit.
    rst = 1'b0;
    p0_valid = 1'b1; p0_rd = 5'd4; p0_data = $urandom;
    p1_valid = 1'b1; p1_rd = 5'd6; p1_data = $urandom;
    for (int i = 0; i < STARVE_LIMIT - 1; i++) begin
      tick();
      e = exp_q.pop_front();
      n_total++;
      if ({rf_we, rf_rd_addr, rf_rd_data} !== e)
        $display("FAIL mid_contend[%0d]: got %h, want %h", i, {rf_we, rf_rd_addr, rf_rd_data}, e);
      else n_pass++;
    end
    rst = 1'b1;
    tick();
    e = exp_q.pop_front();
    rst = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_total++;
    if ({act_p0r, act_p1r} !== 2'b10)
      $display("FAIL mid_starve_cleared: got p0r=%b p1r=%b, want 1 0", act_p0r, act_p1r);
    else n_pass++;
    n_total++;
    if ({rf_we, rf_rd_addr, rf_rd_data} !== e)
      $display("FAIL mid_first_write: got %h, want %h", {rf_we, rf_rd_addr, rf_rd_data}, e);
    else n_pass++;
    p0_valid = 1'b0; p1_valid = 1'b0;
    tick();
    e = exp_q.pop_front();
  endtask

  initial begin
    test_reset();
    test_p0_alone();
    test_contention();
    test_pending();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
